// File: rtl/systolic_pkg.sv
// Shared types for the systolic operand path.
// Lane element, operand vector and swap FSM state.
package systolic_pkg;

    localparam int N_DEF = 8;
    localparam int AW    = 13;

    typedef logic signed [7:0] op_t;
    typedef op_t [N_DEF-1:0] opvec_t;

    typedef enum logic {
        SW_IDLE,
        SW_PEND
    } swap_state_e;

endpackage

// File: rtl/skew_line.sv
// Per-lane skew delay: DEPTH_I data+valid registers.
// Invalid stages hold zero so nothing stale leaks out.
module skew_line
    import systolic_pkg::*;
#(
    parameter int DEPTH_I = 1
) (
    input  logic clk,
    input  logic rst,
    input  op_t  d_i,
    input  logic v_i,
    output op_t  d_o,
    output logic any_o
);

    if (DEPTH_I == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign d_o   = d_i;
        assign any_o = v_i;
    end else begin : g_reg
        op_t              d_q [DEPTH_I];
        logic [DEPTH_I-1:0] v_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < DEPTH_I; j++) begin
                    d_q[j] <= '0;
                end
                v_q <= '0;
            end else begin
                d_q[0] <= d_i;
                v_q[0] <= v_i;
                for (int j = 1; j < DEPTH_I; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign d_o   = d_q[DEPTH_I-1];
        assign any_o = |v_q;
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Ping-pong operand store answering array reads with
// diagonally skewed, zero-padded row/col lanes.
module systolic_operand_feeder #(
    parameter int N     = systolic_pkg::N_DEF,
    parameter int DEPTH = 256,
    parameter int AW    = systolic_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic          ld_sel,
    input  logic [AW-1:0] ld_addr,
    input  logic [N*8-1:0] ld_data,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          active_bank,
    input  logic [AW-1:0] raddr,
    input  logic          ren_n,
    output logic [N*8-1:0] row_in,
    output logic [N*8-1:0] col_in,
    output logic          rd_active
);

    import systolic_pkg::*;

    localparam int IW = $clog2(DEPTH);

    logic [N*8-1:0] mem_a [2][DEPTH];
    logic [N*8-1:0] mem_b [2][DEPTH];

    logic [N*8-1:0] s0_a_q;
    logic [N*8-1:0] s0_b_q;
    logic           s0_v_q;
    logic [N-1:0]   any_a;
    logic [N-1:0]   any_b;

    swap_state_e sw_q;
    logic        active_bank_q;
    logic        swap_ack_q;

    logic          ld_ok;
    logic          rd_ok;
    logic          quiet;
    logic [IW-1:0] ld_idx;
    logic [IW-1:0] rd_idx;

    assign ld_ok  = ld_addr < AW'(DEPTH);
    assign rd_ok  = raddr < AW'(DEPTH);
    assign ld_idx = ld_addr[IW-1:0];
    assign rd_idx = raddr[IW-1:0];
    assign quiet  = !rd_active && ren_n;

    // Host writes only ever land in the shadow bank.
    always_ff @(posedge clk) begin
        if (ld_en && ld_ok) begin
            if (ld_sel) begin
                mem_b[~active_bank_q][ld_idx] <= ld_data;
            end else begin
                mem_a[~active_bank_q][ld_idx] <= ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_a_q <= '0;
            s0_b_q <= '0;
            s0_v_q <= 1'b0;
        end else if (!ren_n && rd_ok) begin
            s0_a_q <= mem_a[active_bank_q][rd_idx];
            s0_b_q <= mem_b[active_bank_q][rd_idx];
            s0_v_q <= 1'b1;
        end else begin
            s0_a_q <= '0;
            s0_b_q <= '0;
            s0_v_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.DEPTH_I(i)) u_a (
            .clk   (clk),
            .rst   (rst),
            .d_i   (s0_a_q[i*8 +: 8]),
            .v_i   (s0_v_q),
            .d_o   (row_in[i*8 +: 8]),
            .any_o (any_a[i])
        );
        skew_line #(.DEPTH_I(i)) u_b (
            .clk   (clk),
            .rst   (rst),
            .d_i   (s0_b_q[i*8 +: 8]),
            .v_i   (s0_v_q),
            .d_o   (col_in[i*8 +: 8]),
            .any_o (any_b[i])
        );
    end

    assign rd_active = s0_v_q | (|any_a) | (|any_b);

    // Bank flips only when no read is issued or in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q          <= SW_IDLE;
            active_bank_q <= 1'b0;
            swap_ack_q    <= 1'b0;
        end else begin
            swap_ack_q <= 1'b0;
            unique case (sw_q)
                SW_IDLE: begin
                    if (swap_req && quiet) begin
                        active_bank_q <= ~active_bank_q;
                        swap_ack_q    <= 1'b1;
                    end else if (swap_req) begin
                        sw_q <= SW_PEND;
                    end
                end
                SW_PEND: begin
                    if (quiet) begin
                        active_bank_q <= ~active_bank_q;
                        swap_ack_q    <= 1'b1;
                        sw_q          <= SW_IDLE;
                    end
                end
            endcase
        end
    end

    assign active_bank = active_bank_q;
    assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: skew, padding,
// signedness, deferred swap, load isolation, reset flush.
module tb_systolic_operand_feeder;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic        ld_sel;
    logic [12:0] ld_addr;
    logic [63:0] ld_data;
    logic        swap_req;
    logic        swap_ack;
    logic        active_bank;
    logic [12:0] raddr;
    logic        ren_n;
    logic [63:0] row_in;
    logic [63:0] col_in;
    logic        rd_active;

    int total = 0;
    int bad   = 0;

    logic [63:0] ra [2][32];
    logic [63:0] rb [2][32];

    systolic_operand_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .ld_en       (ld_en),
        .ld_sel      (ld_sel),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .active_bank (active_bank),
        .raddr       (raddr),
        .ren_n       (ren_n),
        .row_in      (row_in),
        .col_in      (col_in),
        .rd_active   (rd_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] vec(input int k, input logic [7:0] x);
        logic [63:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*8 +: 8] = 8'(k * 16 + i) ^ x;
        end
        return v;
    endfunction

    task automatic load(input logic s, input int a, input logic [63:0] d);
        ld_en   = 1'b1;
        ld_sel  = s;
        ld_addr = 13'(a);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic swap_idle(input logic exp_bank);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swap_ack1", 64'(swap_ack), 64'd1);
        chk("bank_flip", 64'(active_bank), 64'(exp_bank));
        tick();
        chk("swap_ack0", 64'(swap_ack), 64'd0);
    endtask

    // Reads base..base+len-1 from cycle 0 and checks every lane.
    task automatic run(input int base, input int len, input int ncyc,
                       input int bk);
        logic [63:0] er;
        logic [63:0] ec;
        int k;
        for (int c = 0; c < ncyc; c++) begin
            if (c < len) begin
                ren_n = 1'b0;
                raddr = 13'(base + c);
            end else begin
                ren_n = 1'b1;
                raddr = '0;
            end
            er = '0;
            ec = '0;
            for (int i = 0; i < N; i++) begin
                k = c - 1 - i;
                if (k >= 0 && k < len) begin
                    er[i*8 +: 8] = ra[bk][base+k][i*8 +: 8];
                    ec[i*8 +: 8] = rb[bk][base+k][i*8 +: 8];
                end
            end
            chk($sformatf("row a%0d c%0d", base, c), row_in, er);
            chk($sformatf("col a%0d c%0d", base, c), col_in, ec);
            chk($sformatf("act a%0d c%0d", base, c), 64'(rd_active),
                64'(c >= 1 && c <= len + N - 1));
            tick();
        end
        ren_n = 1'b1;
    endtask

    initial begin
        int acks;
        rst      = 1'b1;
        ld_en    = 1'b0;
        ld_sel   = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        swap_req = 1'b0;
        raddr    = '0;
        ren_n    = 1'b1;
        tick();
        tick();
        chk("rst_row", row_in, 64'd0);
        chk("rst_col", col_in, 64'd0);
        chk("rst_act", 64'(rd_active), 64'd0);
        chk("rst_bank", 64'(active_bank), 64'd0);
        chk("rst_ack", 64'(swap_ack), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            ra[1][k] = vec(k, 8'h00);
            rb[1][k] = vec(k, 8'hA5);
        end
        rb[1][10][63:56] = 8'h80;
        rb[1][11][63:56] = 8'h7F;
        for (int k = 0; k < 16; k++) begin
            load(1'b0, k, ra[1][k]);
            load(1'b1, k, rb[1][k]);
        end
        swap_idle(1'b1);

        run(0, 4, 14, 1);
        run(5, 1, 11, 1);
        run(10, 2, 12, 1);

        ren_n = 1'b0;
        raddr = 13'd300;
        tick();
        ren_n = 1'b1;
        chk("oor_act", 64'(rd_active), 64'd0);
        chk("oor_row", row_in, 64'd0);
        repeat (N) tick();
        chk("oor_col", col_in, 64'd0);

        for (int k = 0; k < 21; k++) begin
            ra[0][k] = vec(k, 8'h3C);
            rb[0][k] = vec(k, 8'hC3);
            load(1'b0, k, ra[0][k]);
            load(1'b1, k, rb[0][k]);
        end

        acks = 0;
        fork
            run(0, 16, 30, 1);
            begin
                for (int c = 0; c < 30; c++) begin
                    if (c == 2) begin
                        ld_en    = 1'b1;
                        ld_sel   = 1'b0;
                        ld_addr  = 13'd2;
                        ld_data  = 64'h1122334455667788;
                        ra[0][2] = ld_data;
                    end
                    if (c == 3) ld_en = 1'b0;
                    if (c == 5 || c == 9) swap_req = 1'b1;
                    if (c == 6 || c == 10) swap_req = 1'b0;
                    if (c == 20) begin
                        chk("pend_ack", 64'(swap_ack), 64'd0);
                        chk("pend_bank", 64'(active_bank), 64'd1);
                    end
                    if (c == 24) begin
                        chk("pre_ack", 64'(swap_ack), 64'd0);
                        chk("pre_bank", 64'(active_bank), 64'd1);
                        ld_en     = 1'b1;
                        ld_sel    = 1'b1;
                        ld_addr   = 13'd20;
                        ld_data   = 64'h8070605040302010;
                        rb[0][20] = ld_data;
                    end
                    if (c == 25) begin
                        ld_en = 1'b0;
                        chk("def_ack", 64'(swap_ack), 64'd1);
                        chk("def_bank", 64'(active_bank), 64'd0);
                    end
                    if (c == 26) chk("def_ack0", 64'(swap_ack), 64'd0);
                    if (c >= 6 && swap_ack) acks++;
                    tick();
                end
            end
        join
        chk("one_swap", 64'(acks), 64'd1);

        run(0, 21, 32, 0);

        load(1'b0, 259, 64'hFFFF_FFFF_FFFF_FFFF);
        swap_idle(1'b1);
        run(0, 4, 14, 1);

        acks = 0;
        for (int c = 0; c < 15; c++) begin
            if (c < 3) begin
                ren_n = 1'b0;
                raddr = 13'(c);
            end
            if (c == 1) swap_req = 1'b1;
            if (c == 2) begin
                swap_req = 1'b0;
                chk("t6_act", 64'(rd_active), 64'd1);
                chk("t6_l0", 64'(row_in[7:0]), 64'(ra[1][1][7:0]));
            end
            if (c == 3) begin
                rst   = 1'b1;
                ren_n = 1'b1;
            end
            if (c == 4) begin
                rst = 1'b0;
                chk("t6_row", row_in, 64'd0);
                chk("t6_col", col_in, 64'd0);
                chk("t6_rda", 64'(rd_active), 64'd0);
                chk("t6_bank", 64'(active_bank), 64'd0);
                chk("t6_ack", 64'(swap_ack), 64'd0);
            end
            if (c >= 4 && swap_ack) acks++;
            tick();
        end
        chk("t6_nopend", 64'(acks), 64'd0);
        chk("t6_bank_end", 64'(active_bank), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
